avalon_wait_slave: RTL and testbench

AVALON_WAIT_SLAVE -- requirements
Module: avalon_wait_slave

---
 rtl/avalon_pkg.sv | 19 +
 rtl/avalon_wait_slave_if.sv | 34 +++
 rtl/avs_regbank.sv | 36 +++
 rtl/avalon_wait_slave.sv | 140 ++++++++++++++
 tb/tb_avalon_wait_slave.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/avalon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : avalon_pkg
// Brief    : Shared types and limits for the Avalon wait-state slave.
// Revision : 1.0
// ============================================================================
package avalon_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_e;

   typedef logic [3:0] cnt_t;

   localparam int MAX_DELAY = 15;

endpackage
`default_nettype wire

// File: rtl/avalon_wait_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : avalon_wait_slave_if
// Brief    : Avalon-MM bus bundle between a master and the wait-state slave.
// Revision : 1.0
// ============================================================================
interface avalon_wait_slave_if #(
   parameter int NBDATABYTES = 2,
   parameter int NBADDRBITS  = 4
);
   localparam int DW = 8 * NBDATABYTES;

   logic [NBADDRBITS-1:0]  address;
   logic [NBDATABYTES-1:0] byteenable;
   logic [DW-1:0]          writedata;
   logic                   read;
   logic                   write;
   logic [DW-1:0]          readdata;
   logic                   waitrequest;
   logic                   readdatavalid;
   logic                   proto_err;

   modport master (
      output address, byteenable, writedata, read, write,
      input  readdata, waitrequest, readdatavalid, proto_err
   );

   modport slave (
      input  address, byteenable, writedata, read, write,
      output readdata, waitrequest, readdatavalid, proto_err
   );

endinterface
`default_nettype wire

// File: rtl/avs_regbank.sv
`default_nettype none
// ============================================================================
// Module   : avs_regbank
// Brief    : Byte-enabled register bank, one write port, async read, clears on reset.
// Revision : 1.0
// ============================================================================
module avs_regbank #(
   parameter int NBDATABYTES = 2,
   parameter int NBADDRBITS  = 4
) (
   input  wire logic                     clk,
   input  wire logic                     rst,
   input  wire logic                     we,
   input  wire logic [NBDATABYTES-1:0]   be,
   input  wire logic [NBADDRBITS-1:0]    addr,
   input  wire logic [8*NBDATABYTES-1:0] wdata,
   output logic      [8*NBDATABYTES-1:0] rdata
);
   localparam int DEPTH = 1 << NBADDRBITS;

   logic [8*NBDATABYTES-1:0] r_mem [DEPTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int w = 0; w < DEPTH; w++) r_mem[w] <= '0;
      end else if (we) begin
         for (int b = 0; b < NBDATABYTES; b++) begin
            if (be[b]) r_mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/avalon_wait_slave.sv
`default_nettype none
// ============================================================================
// Module   : avalon_wait_slave
// Brief    : Avalon-MM slave with fixed read/write wait states and protocol checks.
//            Define AVS_READDATAVALID_EN for registered, pipelined read data.
// Revision : 1.0
// ============================================================================
module avalon_wait_slave
   import avalon_pkg::*;
#(
   parameter int NBDATABYTES = 2,
   parameter int NBADDRBITS  = 4,
   parameter int WRITEDELAY  = 2,
   parameter int READDELAY   = 1
) (
   input wire logic          clk,
   input wire logic          rst,
   avalon_wait_slave_if.slave bus
);
   localparam int   DW     = 8 * NBDATABYTES;
   localparam cnt_t c_WR_D = cnt_t'(WRITEDELAY);
   localparam cnt_t c_RD_D = cnt_t'(READDELAY);

   generate
      if (WRITEDELAY > MAX_DELAY || READDELAY > MAX_DELAY || WRITEDELAY < 0 ||
          READDELAY < 0 || NBDATABYTES < 1) begin : g_param_err
         $fatal(1, "avalon_wait_slave: illegal delay or data-width parameter");
      end
   endgenerate

   // Reset asserts immediately but releases on a clock edge.
   logic r_rst_sync;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_rst_sync <= 1'b0;
      else      r_rst_sync <= 1'b1;
   end

   logic w_rst_n;
   assign w_rst_n = r_rst_sync;

   state_e                 r_state;
   cnt_t                   r_cnt;
   logic                   r_is_wr;
   logic [NBADDRBITS-1:0]  r_addr;
   logic [NBDATABYTES-1:0] r_be;
   logic [DW-1:0]          r_wdata;
   logic                   r_perr;

   logic          w_rd_req, w_wr_req, w_both, w_start, w_hold, w_abort;
   logic          w_complete, w_qual_chg, w_rd_done, w_wr_commit;
   cnt_t          w_delay;
   logic [DW-1:0] w_bank_rd;

   assign w_rd_req    = bus.read & ~bus.write;
   assign w_wr_req    = bus.write & ~bus.read;
   assign w_both      = bus.read & bus.write;
   assign w_delay     = w_wr_req ? c_WR_D : c_RD_D;
   assign w_start     = w_rst_n & (r_state == IDLE) & (w_rd_req | w_wr_req);
   assign w_hold      = w_rst_n & (r_state == WAIT) & (r_is_wr ? w_wr_req : w_rd_req);
   assign w_abort     = w_rst_n & (r_state == WAIT) & ~w_hold;
   assign w_complete  = (w_start & (w_delay == '0)) | (w_hold & (r_cnt == '0));
   assign w_rd_done   = w_complete & w_rd_req;
   assign w_wr_commit = w_complete & w_wr_req;
   assign w_qual_chg  = w_hold & ((bus.address != r_addr) | (bus.byteenable != r_be) |
                                  (bus.writedata != r_wdata));

   assign bus.waitrequest = (w_start & (w_delay != '0)) | (w_hold & (r_cnt != '0));

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_is_wr <= 1'b0;
         r_addr  <= '0;
         r_be    <= '0;
         r_wdata <= '0;
         r_perr  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_start && w_delay != '0) begin
                  r_state <= WAIT;
                  r_cnt   <= cnt_t'(w_delay - 4'd1);
                  r_is_wr <= w_wr_req;
                  r_addr  <= bus.address;
                  r_be    <= bus.byteenable;
                  r_wdata <= bus.writedata;
               end
            end
            WAIT: begin
               if (w_abort || r_cnt == '0) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt   <= cnt_t'(r_cnt - 4'd1);
               end
            end
            default: r_state <= IDLE;
         endcase
         // Sticky until reset; later traffic never clears it.
         if ((r_state == IDLE && w_both) || w_abort || w_qual_chg) r_perr <= 1'b1;
      end
   end

   assign bus.proto_err = r_perr;

   avs_regbank #(
      .NBDATABYTES (NBDATABYTES),
      .NBADDRBITS  (NBADDRBITS)
   ) u_regbank (
      .clk   (clk),
      .rst   (w_rst_n),
      .we    (w_wr_commit),
      .be    (bus.byteenable),
      .addr  (bus.address),
      .wdata (bus.writedata),
      .rdata (w_bank_rd)
   );

`ifdef AVS_READDATAVALID_EN
   logic [DW-1:0] r_rdata;
   logic          r_rdv;
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_rdata <= '0;
         r_rdv   <= 1'b0;
      end else begin
         r_rdata <= w_rd_done ? w_bank_rd : '0;
         r_rdv   <= w_rd_done;
      end
   end
   assign bus.readdata      = r_rdata;
   assign bus.readdatavalid = r_rdv;
`else
   assign bus.readdata      = w_rd_done ? w_bank_rd : '0;
   assign bus.readdatavalid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_avalon_wait_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_wait_slave
// Brief    : Scoreboard bench for avalon_wait_slave (default and zero-delay instances).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_avalon_wait_slave;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   avalon_wait_slave_if #(.NBDATABYTES(2), .NBADDRBITS(4)) bus  ();
   avalon_wait_slave_if #(.NBDATABYTES(2), .NBADDRBITS(4)) bus0 ();

   avalon_wait_slave #(
      .NBDATABYTES(2), .NBADDRBITS(4), .WRITEDELAY(2), .READDELAY(1)
   ) dut (.clk(clk), .rst(rst), .bus(bus));

   avalon_wait_slave #(
      .NBDATABYTES(2), .NBADDRBITS(4), .WRITEDELAY(0), .READDELAY(0)
   ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] mdl [16];
   logic [15:0] sb_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Read results leave the DUT here and are matched against the queue.
   always @(negedge clk) begin
`ifdef AVS_READDATAVALID_EN
      if (bus.readdatavalid) begin
`else
      if (rst && bus.read && !bus.write && !bus.waitrequest) begin
`endif
         if (sb_q.size() == 0) chk("sb_unexpected", 32'd1, 32'd0);
         else                  chk("rd_data", {16'h0, bus.readdata}, {16'h0, sb_q.pop_front()});
      end
   end

   task automatic do_write(input logic [3:0] a, input logic [15:0] d,
                           input logic [1:0] be, input int exp_waits);
      int waits = 0;
      bit done  = 1'b0;
      bus.address = a; bus.writedata = d; bus.byteenable = be; bus.write = 1'b1;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (bus.waitrequest) waits++;
         else                 done = 1'b1;
      end
      @(posedge clk);
      for (int b = 0; b < 2; b++) if (be[b]) mdl[a][8*b +: 8] = d[8*b +: 8];
      #1 bus.write = 1'b0;
      if (!done) chk("wr_timeout", 32'd0, 32'd1);
      chk("wr_waits", waits, exp_waits);
   endtask

   task automatic do_read(input logic [3:0] a, input int exp_waits);
      int waits = 0;
      bit done  = 1'b0;
      sb_q.push_back(mdl[a]);
      bus.address = a; bus.read = 1'b1;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (bus.waitrequest) waits++;
         else                 done = 1'b1;
      end
      @(posedge clk);
      #1 bus.read = 1'b0;
      if (!done) chk("rd_timeout", 32'd0, 32'd1);
      chk("rd_waits", waits, exp_waits);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) mdl[i] = 16'h0;
      bus.address = '0; bus.byteenable = '0; bus.writedata = '0;
      bus.read = 1'b0;  bus.write = 1'b0;
      bus0.address = '0; bus0.byteenable = '0; bus0.writedata = '0;
      bus0.read = 1'b0;  bus0.write = 1'b0;

      // Reset with a read request pending: outputs must stay quiet.
      bus.read = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_waitreq", {31'h0, bus.waitrequest}, 32'd0);
      chk("rst_rdv",     {31'h0, bus.readdatavalid}, 32'd0);
      chk("rst_rdata",   {16'h0, bus.readdata}, 32'd0);
      chk("rst_perr",    {31'h0, bus.proto_err}, 32'd0);
      bus.read = 1'b0;
      step(); rst = 1'b1;
      repeat (3) step();

      // Full-word, partial-lane and upper-lane writes with read-back.
      do_write(4'd3, 16'hBEEF, 2'b11, 2);
      do_read(4'd3, 1);
      do_write(4'd5, 16'hAAAA, 2'b11, 2);
      do_write(4'd5, 16'h1234, 2'b01, 2);
      do_read(4'd5, 1);
      do_write(4'd7, 16'h5678, 2'b10, 2);
      do_read(4'd7, 1);
      @(negedge clk);
      chk("perr_clean", {31'h0, bus.proto_err}, 32'd0);

      // Zero-delay instance: single-cycle write then read.
      step();
      bus0.address = 4'd9; bus0.writedata = 16'hC3A5; bus0.byteenable = 2'b11; bus0.write = 1'b1;
      @(negedge clk);
      chk("d0_wr_wait", {31'h0, bus0.waitrequest}, 32'd0);
      step();
      bus0.write = 1'b0; bus0.read = 1'b1;
      @(negedge clk);
      chk("d0_rd_wait", {31'h0, bus0.waitrequest}, 32'd0);
`ifdef AVS_READDATAVALID_EN
      chk("d0_rdv_early",  {31'h0, bus0.readdatavalid}, 32'd0);
      chk("d0_data_early", {16'h0, bus0.readdata}, 32'd0);
`else
      chk("d0_rd_data", {16'h0, bus0.readdata}, 32'h0000C3A5);
`endif
      step();
      bus0.read = 1'b0;
      @(negedge clk);
`ifdef AVS_READDATAVALID_EN
      chk("d0_rdv",      {31'h0, bus0.readdatavalid}, 32'd1);
      chk("d0_rdv_data", {16'h0, bus0.readdata}, 32'h0000C3A5);
`else
      chk("d0_rdv_tied", {31'h0, bus0.readdatavalid}, 32'd0);
      chk("d0_data_idle", {16'h0, bus0.readdata}, 32'd0);
`endif

      // Write dropped mid-wait: no commit, error flagged.
      step();
      bus.address = 4'd5; bus.writedata = 16'hFFFF; bus.byteenable = 2'b11; bus.write = 1'b1;
      @(negedge clk);
      chk("ab_start_wait", {31'h0, bus.waitrequest}, 32'd1);
      step();
      bus.write = 1'b0;
      @(negedge clk);
      chk("ab_wait_low", {31'h0, bus.waitrequest}, 32'd0);
      step();
      @(negedge clk);
      chk("ab_perr", {31'h0, bus.proto_err}, 32'd1);
      step();
      do_read(4'd5, 1);

      // Reset in the middle of a write's wait states.
      bus.address = 4'd3; bus.writedata = 16'h1111; bus.byteenable = 2'b11; bus.write = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("rw_waitreq", {31'h0, bus.waitrequest}, 32'd0);
      chk("rw_rdata",   {16'h0, bus.readdata}, 32'd0);
      chk("rw_rdv",     {31'h0, bus.readdatavalid}, 32'd0);
      chk("rw_perr",    {31'h0, bus.proto_err}, 32'd0);
      bus.write = 1'b0;
      step(); rst = 1'b1;
      repeat (3) step();
      for (int i = 0; i < 16; i++) mdl[i] = 16'h0;
      do_read(4'd3, 1);
      do_read(4'd5, 1);
      @(negedge clk);
      chk("perr_after_rst", {31'h0, bus.proto_err}, 32'd0);

      // Read and write together: ignored, flagged, sticky.
      step();
      bus.address = 4'd2; bus.writedata = 16'h7777; bus.byteenable = 2'b11;
      bus.read = 1'b1; bus.write = 1'b1;
      @(negedge clk);
      chk("both_wait", {31'h0, bus.waitrequest}, 32'd0);
      step();
      bus.read = 1'b0; bus.write = 1'b0;
      @(negedge clk);
      chk("both_perr", {31'h0, bus.proto_err}, 32'd1);
      step();
      do_read(4'd2, 1);
      repeat (5) step();
      @(negedge clk);
      chk("perr_sticky", {31'h0, bus.proto_err}, 32'd1);

      repeat (3) step();
      chk("sb_empty", sb_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
